uart_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_cfg.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_cfg UART.
//   - parity mode constants and line-level start/stop bit values
//   - TX and RX engine state encodings
//   - parity_bit(): parity bit for a data word under a given mode
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  // Data is zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
    logic p;
    p = 1'b0;
    if (mode == PARITY_EVEN) p = ^data;
    else if (mode == PARITY_ODD) p = ~^data;
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO for the UART transmit path.
//   clk, reset   : clock, synchronous active-high reset (empties the FIFO)
//   wr_en_i      : push wr_data_i; ignored while full
//   rd_en_i      : pop the head word; ignored while empty
//   rd_data_o    : head word (valid while !empty_o)
//   full_o/empty_o : occupancy flags
module uart_tx_fifo #(
  parameter int unsigned Width     = 8,
  parameter int unsigned DepthBits = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 2 ** DepthBits;
  localparam logic [DepthBits:0] PtrOne = (DepthBits + 1)'(1);

  logic [Width-1:0] mem_q [Depth];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [DepthBits:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_wr, do_rd;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[DepthBits] != rd_ptr_q[DepthBits]) &&
                     (wr_ptr_q[DepthBits-1:0] == rd_ptr_q[DepthBits-1:0]);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[DepthBits-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[DepthBits-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART: TX FIFO + TX engine, synchronised RX engine with error flags.
//   clk, reset          : clock, synchronous active-high reset
//   baud_div            : bit period = baud_div+1 clocks, latched at each frame start
//   tx_we/tx_data       : push a word; tx_full, tx_busy report FIFO/engine state
//   txd                 : serial output, idle high
//   rxd                 : asynchronous serial input
//   rx_valid            : one-cycle pulse with rx_data, rx_perr, rx_ferr
//   rx_ack              : consumer took rx_data; rx_overrun is sticky on a missed word
module uart_cfg
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned PARITY          = 0,
  parameter int unsigned STOP_BITS       = 1,
  parameter int unsigned FIFO_DEPTH_BITS = 4,
  parameter int unsigned SYNC_DEPTH      = 3,
  parameter int unsigned DIV_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 tx_we,
  input  logic [WIDTH-1:0]     tx_data,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 txd,
  input  logic                 rxd,
  output logic                 rx_valid,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  input  logic                 rx_ack,
  output logic                 rx_overrun
);

  localparam int unsigned CntW = $clog2(WIDTH + 3);
  localparam logic [CntW-1:0]      LastData = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]      LastStop = CntW'(STOP_BITS - 1);
  localparam logic [CntW-1:0]      CntOne   = CntW'(1);
  localparam logic [DIV_WIDTH-1:0] BaudOne  = DIV_WIDTH'(1);

  // ---------------- TX ----------------
  tx_state_e tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_div_q, tx_div_d, tx_baud_q, tx_baud_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [WIDTH-1:0]     tx_shift_q, tx_shift_d, fifo_rdata;
  logic                 tx_par_q, tx_par_d, txd_q, txd_d;
  logic                 fifo_pop, fifo_empty, tx_load;

  uart_tx_fifo #(
    .Width    (WIDTH),
    .DepthBits(FIFO_DEPTH_BITS)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (tx_we),
    .wr_data_i(tx_data),
    .rd_en_i  (fifo_pop),
    .rd_data_o(fifo_rdata),
    .full_o   (tx_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_baud_d  = tx_baud_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    fifo_pop   = 1'b0;
    unique case (tx_state_q)
      TxIdle: if (!fifo_empty) tx_load = 1'b1;
      TxStart: begin
        if (tx_baud_q != '0) tx_baud_d = tx_baud_q - BaudOne;
        else begin
          tx_state_d = TxData;
          tx_baud_d  = tx_div_q;
          tx_cnt_d   = '0;
          txd_d      = tx_shift_q[0];
        end
      end
      TxData: begin
        if (tx_baud_q != '0) tx_baud_d = tx_baud_q - BaudOne;
        else begin
          tx_baud_d = tx_div_q;
          if (tx_cnt_q == LastData) begin
            if (PARITY != PARITY_NONE) begin
              tx_state_d = TxParity;
              txd_d      = tx_par_q;
            end else begin
              tx_state_d = TxStop;
              txd_d      = STOP_BIT;
              tx_cnt_d   = '0;
            end
          end else begin
            tx_cnt_d   = tx_cnt_q + CntOne;
            tx_shift_d = tx_shift_q >> 1;
            txd_d      = tx_shift_q[1];
          end
        end
      end
      TxParity: begin
        if (tx_baud_q != '0) tx_baud_d = tx_baud_q - BaudOne;
        else begin
          tx_state_d = TxStop;
          tx_baud_d  = tx_div_q;
          tx_cnt_d   = '0;
          txd_d      = STOP_BIT;
        end
      end
      TxStop: begin
        if (tx_baud_q != '0) tx_baud_d = tx_baud_q - BaudOne;
        else if (tx_cnt_q != LastStop) begin
          tx_cnt_d  = tx_cnt_q + CntOne;
          tx_baud_d = tx_div_q;
        end else if (!fifo_empty) tx_load = 1'b1;  // chain next frame, no idle gap
        else tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_load) begin
      fifo_pop   = 1'b1;
      tx_state_d = TxStart;
      tx_div_d   = baud_div;
      tx_baud_d  = baud_div;
      tx_shift_d = fifo_rdata;
      tx_par_d   = parity_bit(9'(fifo_rdata), PARITY);
      txd_d      = START_BIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_div_q   <= '0;
      tx_baud_q  <= '0;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_baud_q  <= tx_baud_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  assign txd     = txd_q;
  assign tx_busy = !fifo_empty || (tx_state_q != TxIdle);

  // ---------------- RX ----------------
  rx_state_e rx_state_q, rx_state_d;
  logic [SYNC_DEPTH-1:0] sync_q;
  logic [DIV_WIDTH-1:0]  rx_div_q, rx_div_d, rx_baud_q, rx_baud_d, rx_half;
  logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0]      rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic rx_bit, rx_par_q, rx_par_d, rx_done;
  logic rx_valid_q, rx_valid_d, rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic pending_q, pending_d, overrun_q, overrun_d;

  assign rx_bit = sync_q[SYNC_DEPTH-1];
  // (baud_div+1)/2 - 1 without needing a wider intermediate
  assign rx_half = (baud_div >> 1) - DIV_WIDTH'(!baud_div[0]);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_div_q;
    rx_baud_d  = rx_baud_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_bit == START_BIT) begin
          rx_state_d = RxStart;
          rx_div_d   = baud_div;
          rx_baud_d  = rx_half;
        end
      end
      RxStart: begin
        if (rx_baud_q != '0) rx_baud_d = rx_baud_q - BaudOne;
        else if (rx_bit != START_BIT) rx_state_d = RxIdle;  // glitch, not a start bit
        else begin
          rx_state_d = RxData;
          rx_baud_d  = rx_div_q;
          rx_cnt_d   = '0;
        end
      end
      RxData: begin
        if (rx_baud_q != '0) rx_baud_d = rx_baud_q - BaudOne;
        else begin
          rx_baud_d  = rx_div_q;
          rx_shift_d = {rx_bit, rx_shift_q[WIDTH-1:1]};
          if (rx_cnt_q == LastData) rx_state_d = (PARITY != PARITY_NONE) ? RxParity : RxStop;
          else rx_cnt_d = rx_cnt_q + CntOne;
        end
      end
      RxParity: begin
        if (rx_baud_q != '0) rx_baud_d = rx_baud_q - BaudOne;
        else begin
          rx_par_d   = rx_bit;
          rx_state_d = RxStop;
          rx_baud_d  = rx_div_q;
        end
      end
      RxStop: begin
        // Only the first stop bit is checked; rearm for the next start at once.
        if (rx_baud_q != '0) rx_baud_d = rx_baud_q - BaudOne;
        else begin
          rx_done    = 1'b1;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase

    rx_valid_d = rx_done;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_done) begin
      rx_data_d = rx_shift_q;
      rx_ferr_d = (rx_bit != STOP_BIT);
      rx_perr_d = (PARITY != PARITY_NONE) &&
                  (rx_par_q != parity_bit(9'(rx_shift_q), PARITY));
    end
    // A valid in the same cycle as an ack re-arms pending for the new word.
    pending_d = rx_valid_q ? 1'b1 : (rx_ack ? 1'b0 : pending_q);
    overrun_d = overrun_q || (rx_valid_q && pending_q && !rx_ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      rx_state_q <= RxIdle;
      rx_div_q   <= '0;
      rx_baud_q  <= '0;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_DEPTH-2:0], rxd};
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_baud_q  <= rx_baud_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign rx_perr    = rx_perr_q;
  assign rx_ferr    = rx_ferr_q;
  assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: dut0 (no parity) runs in loopback, dut1 (even parity) has its
// rxd driven directly. Expected frames come from frame_bits(), built bit by bit.
module tb_uart_cfg;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [15:0]   baud_div0, baud_div1;
  logic          tx_we0, tx_we1, rx_ack0, rx_ack1, rxd1;
  logic [W-1:0]  tx_data0, tx_data1, rx_data0, rx_data1;
  logic          tx_full0, tx_full1, tx_busy0, tx_busy1, txd0, txd1;
  logic          rx_valid0, rx_valid1, rx_perr0, rx_perr1, rx_ferr0, rx_ferr1;
  logic          rx_overrun0, rx_overrun1;

  uart_cfg #(.WIDTH(W), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .baud_div(baud_div0), .tx_we(tx_we0), .tx_data(tx_data0),
    .tx_full(tx_full0), .tx_busy(tx_busy0), .txd(txd0), .rxd(txd0), .rx_valid(rx_valid0),
    .rx_data(rx_data0), .rx_perr(rx_perr0), .rx_ferr(rx_ferr0), .rx_ack(rx_ack0),
    .rx_overrun(rx_overrun0)
  );

  uart_cfg #(.WIDTH(W), .PARITY(1)) u_dut1 (
    .clk(clk), .reset(reset), .baud_div(baud_div1), .tx_we(tx_we1), .tx_data(tx_data1),
    .tx_full(tx_full1), .tx_busy(tx_busy1), .txd(txd1), .rxd(rxd1), .rx_valid(rx_valid1),
    .rx_data(rx_data1), .rx_perr(rx_perr1), .rx_ferr(rx_ferr1), .rx_ack(rx_ack1),
    .rx_overrun(rx_overrun1)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
    logic         ferr;
  } rx_rec_t;

  rx_rec_t     rxq0[$], rxq1[$];
  int unsigned vtime0[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid0) begin
      rxq0.push_back({rx_data0, rx_perr0, rx_ferr0});
      vtime0.push_back(cyc);
    end
    if (rx_valid1) rxq1.push_back({rx_data1, rx_perr1, rx_ferr1});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line-level frame, index 0 first on the wire; one stop bit.
  function automatic int frame_len(input int par_mode);
    return 1 + W + ((par_mode != 0) ? 1 : 0) + 1;
  endfunction

  function automatic logic [15:0] frame_bits(input logic [W-1:0] w, input int par_mode);
    logic [15:0] f;
    int ones;
    f = 16'hFFFF;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < W; i++) begin
      f[1+i] = w[i];
      ones += int'(w[i]);
    end
    if (par_mode == 1) f[1+W] = (ones % 2 == 1);
    else if (par_mode == 2) f[1+W] = (ones % 2 == 0);
    return f;
  endfunction

  // Push one word into an idle DUT and check txd at the first and last cycle of every bit.
  task automatic tx_check(input int sel, input logic [W-1:0] w, input int d, input bit scramble);
    logic [15:0] f;
    int n;
    f = frame_bits(w, sel);
    n = frame_len(sel);
    if (sel == 0) begin baud_div0 = 16'(d); tx_we0 = 1'b1; tx_data0 = w; end
    else begin baud_div1 = 16'(d); tx_we1 = 1'b1; tx_data1 = w; end
    @(negedge clk);
    tx_we0 = 1'b0;
    tx_we1 = 1'b0;
    check_eq("tx_high_before_start", (sel != 0) ? txd1 : txd0, 1);
    @(negedge clk);
    if (scramble) begin
      if (sel == 0) baud_div0 = 16'(d + 7);
      else baud_div1 = 16'(d + 7);
    end
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c <= d; c++) begin
        if (c == 0 || c == d)
          check_eq($sformatf("tx_w%0h_bit%0d_c%0d", w, k, c), (sel != 0) ? txd1 : txd0, f[k]);
        @(negedge clk);
      end
    end
    check_eq("tx_idle_after", (sel != 0) ? txd1 : txd0, 1);
    if (sel == 0) baud_div0 = 16'(d);
    else baud_div1 = 16'(d);
  endtask

  // Drive an even-parity frame into dut1, optionally corrupting parity or stop bit.
  task automatic drive_rx(input logic [W-1:0] w, input bit bad_par, input bit bad_stop,
                          input int d);
    logic [15:0] f;
    int n;
    f = frame_bits(w, 1);
    n = frame_len(1);
    if (bad_par) f[1+W] = ~f[1+W];
    if (bad_stop) f[n-1] = 1'b0;
    for (int k = 0; k < n; k++) begin
      rxd1 = f[k];
      repeat (d + 1) @(negedge clk);
    end
    rxd1 = 1'b1;
  endtask

  task automatic wait_rx(input int sel, input int n, input int budget, input string tag);
    int t;
    t = 0;
    while ((((sel == 0) ? rxq0.size() : rxq1.size()) < n) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, (sel == 0) ? rxq0.size() : rxq1.size(), n);
  endtask

  task automatic check_rx1(input string tag, input logic [W-1:0] w, input bit perr,
                           input bit ferr);
    wait_rx(1, 1, 40, {tag, "_count"});
    if (rxq1.size() > 0) begin
      check_eq({tag, "_data"}, rxq1[0].data, w);
      check_eq({tag, "_perr"}, rxq1[0].perr, perr);
      check_eq({tag, "_ferr"}, rxq1[0].ferr, ferr);
    end
    rxq1.delete();
  endtask

  task automatic ack1();
    rx_ack1 = 1'b1;
    @(negedge clk);
    rx_ack1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w, w2;
    int d, bad_gaps, low_cycles;
    reset = 1'b1;
    baud_div0 = 16'd9; baud_div1 = 16'd9;
    tx_we0 = 1'b0; tx_we1 = 1'b0; tx_data0 = '0; tx_data1 = '0;
    rx_ack0 = 1'b0; rx_ack1 = 1'b0; rxd1 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_flags0", {txd0, tx_full0, tx_busy0, rx_valid0, rx_perr0, rx_ferr0,
                            rx_overrun0}, 7'b1000000);
    check_eq("rst_flags1", {txd1, tx_full1, tx_busy1, rx_valid1, rx_perr1, rx_ferr1,
                            rx_overrun1}, 7'b1000000);
    check_eq("rst_rx_data0", rx_data0, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback, no parity: 0x55 at baud_div=9, then random words and divisors
    for (int i = 0; i < 5; i++) begin
      w = (i == 0) ? 8'h55 : 8'($urandom);
      d = (i == 0) ? 9 : int'($urandom_range(3, 12));
      rxq0.delete();
      tx_check(0, w, d, 1'b0);
      wait_rx(0, 1, 30, "lb_count");
      if (rxq0.size() > 0) begin
        check_eq("lb_data", rxq0[0].data, w);
        check_eq("lb_perr", rxq0[0].perr, 0);
        check_eq("lb_ferr", rxq0[0].ferr, 0);
      end
    end

    // Even parity TX: 0xA7 has five ones so parity bit is 1; divisor changed mid-frame
    tx_check(1, 8'hA7, 9, 1'b1);
    tx_check(1, 8'($urandom), 9, 1'b1);

    // Even parity RX: good frame, bad parity, bad stop bit
    w = 8'($urandom);
    drive_rx(w, 1'b0, 1'b0, 9);
    check_rx1("rx_good", w, 1'b0, 1'b0);
    ack1();
    w = 8'($urandom);
    drive_rx(w, 1'b1, 1'b0, 9);
    check_rx1("rx_badpar", w, 1'b1, 1'b0);
    ack1();
    w = 8'($urandom);
    drive_rx(w, 1'b0, 1'b1, 9);
    check_rx1("rx_badstop", w, 1'b0, 1'b1);
    ack1();
    repeat (40) @(negedge clk);
    check_eq("rx_no_valid_after_badstop", rxq1.size(), 0);

    // False start: 3 low cycles is shorter than the half-bit check point
    rxd1 = 1'b0;
    repeat (3) @(negedge clk);
    rxd1 = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("false_start_no_valid", rxq1.size(), 0);

    // Overrun: two frames without ack
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    rxq1.delete();
    w = 8'($urandom); w2 = ~w;
    drive_rx(w, 1'b0, 1'b0, 9);
    check_rx1("ovr_first", w, 1'b0, 1'b0);
    check_eq("ovr_not_yet", rx_overrun1, 0);
    drive_rx(w2, 1'b0, 1'b0, 9);
    check_rx1("ovr_second", w2, 1'b0, 1'b0);
    check_eq("ovr_set", rx_overrun1, 1);
    check_eq("ovr_data_second", rx_data1, w2);

    // Same with an ack between frames: no overrun
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    drive_rx(w, 1'b0, 1'b0, 9);
    check_rx1("ack_first", w, 1'b0, 1'b0);
    ack1();
    drive_rx(w2, 1'b0, 1'b0, 9);
    check_rx1("ack_second", w2, 1'b0, 1'b0);
    check_eq("ack_no_overrun", rx_overrun1, 0);

    // FIFO fill at baud_div=3. Word 0 is popped into the TX engine on the cycle after
    // it is written, so the FIFO itself fills on the 17th write (0x10) and 0x11 drops.
    baud_div0 = 16'd3;
    rxq0.delete();
    vtime0.delete();
    for (int i = 0; i < 18; i++) begin
      tx_we0 = 1'b1;
      tx_data0 = 8'(i);
      @(negedge clk);
      if (i == 15) check_eq("fifo_not_full_16", tx_full0, 0);
      if (i == 16) check_eq("fifo_full_17", tx_full0, 1);
    end
    tx_we0 = 1'b0;
    check_eq("fifo_busy", tx_busy0, 1);
    wait_rx(0, 17, 17 * 40 + 100, "fill_count");
    for (int i = 0; i < 17; i++)
      if (i < rxq0.size()) check_eq($sformatf("fill_data%0d", i), rxq0[i].data, i);
    bad_gaps = 0;
    for (int i = 1; i < vtime0.size(); i++)
      if (vtime0[i] - vtime0[i-1] != 40) bad_gaps++;
    check_eq("fill_b2b_bad_gaps", bad_gaps, 0);
    repeat (60) @(negedge clk);
    check_eq("fill_dropped", rxq0.size(), 17);
    check_eq("fill_idle", tx_busy0, 0);

    // Reset during data bit 3 with a second word queued
    baud_div0 = 16'd9;
    rxq0.delete();
    w = 8'($urandom); w2 = 8'($urandom);
    tx_we0 = 1'b1; tx_data0 = w; @(negedge clk);
    tx_data0 = w2; @(negedge clk);
    tx_we0 = 1'b0;
    repeat (42) @(negedge clk);
    check_eq("mid_bit3_value", txd0, w[3]);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_txd", txd0, 1);
    check_eq("mid_rst_busy", tx_busy0, 0);
    check_eq("mid_rst_full", tx_full0, 0);
    reset = 1'b0;
    low_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd0 == 1'b0) low_cycles++;
    end
    check_eq("mid_rst_fifo_empty", low_cycles, 0);
    check_eq("mid_rst_no_rx", rxq0.size(), 0);
    w = 8'($urandom);
    tx_check(0, w, 9, 1'b0);
    wait_rx(0, 1, 30, "post_rst_count");
    if (rxq0.size() > 0) check_eq("post_rst_data", rxq0[0].data, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
